// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 serial-memory responder (READ 0x03 / WRITE 0x02, 24-bit address)
// over an internal byte RAM, oversampling sck/cs/mosi in the clk domain.
module spi_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    input  logic        hold_n,
    output logic        miso,
    output logic        miso_oe,
    output logic        busy,
    output logic [7:0]  last_cmd,
    output logic        cmd_err,
    output logic [15:0] byte_cnt
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE} state_t;
    state_t state, state_d;
    logic [SYNC_STAGES:0] sck_sh, cs_sh;
    logic [SYNC_STAGES-1:0] mosi_sh;
    logic [7:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr, addr_sh, addr_next;
    logic [6:0] rx;
    logic [7:0] tx, wr_byte, in_byte;
    logic [4:0] bit_cnt;
    logic [15:0] byte_inc;
    logic load, wr_pend;
    logic mosi_s, rise, fall, cs_fall, cs_rise, last_bit, cmd_ok;

    // the extra top stage of sck_sh/cs_sh holds the previous synchronized value for edge detection
    assign mosi_s = mosi_sh[SYNC_STAGES-1];
    assign rise = hold_n & sck_sh[SYNC_STAGES-1] & ~sck_sh[SYNC_STAGES];
    assign fall = hold_n & ~sck_sh[SYNC_STAGES-1] & sck_sh[SYNC_STAGES];
    assign cs_fall = ~cs_sh[SYNC_STAGES-1] & cs_sh[SYNC_STAGES];
    assign cs_rise = cs_sh[SYNC_STAGES-1] & ~cs_sh[SYNC_STAGES];
    assign in_byte = {rx, mosi_s};
    assign addr_next = {addr_sh[ADDR_W-2:0], mosi_s};
    assign cmd_ok = in_byte == 8'h02 || in_byte == 8'h03;
    assign last_bit = bit_cnt == (state == ADDR ? 5'd23 : 5'd7);
    assign byte_inc = byte_cnt + 16'(byte_cnt != 16'hFFFF);

    always_ff @(posedge clk) begin
        sck_sh <= {sck_sh[SYNC_STAGES-1:0], sck};
        cs_sh <= {cs_sh[SYNC_STAGES-1:0], cs};
        mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], mosi};
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state;
        if (cs_rise) state_d = IDLE;
        else if (state == IDLE) state_d = cs_fall ? CMD : IDLE;
        else if (rise && last_bit && state == CMD) state_d = cmd_ok ? ADDR : IGNORE;
        else if (rise && last_bit && state == ADDR) state_d = last_cmd == 8'h03 ? RD_DATA : WR_DATA;
    end

    always_ff @(posedge clk) if (wr_pend && !rst) mem[ptr] <= wr_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            miso <= 1'b0;
            miso_oe <= 1'b0;
            busy <= 1'b0;
            last_cmd <= 8'h00;
            cmd_err <= 1'b0;
            byte_cnt <= 16'h0000;
            bit_cnt <= 5'd0;
            load <= 1'b0;
            wr_pend <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            load <= 1'b0;
            wr_pend <= 1'b0;
            if (wr_pend) begin
                ptr <= ptr + ADDR_W'(1);
                byte_cnt <= byte_inc;
            end
            if (load) tx <= mem[ptr];
            // cs rise wins over any same-cycle sck edge, so a byte completing with it is dropped
            if (cs_rise) begin
                busy <= 1'b0;
                miso <= 1'b0;
                miso_oe <= 1'b0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt <= 5'd0;
                    byte_cnt <= 16'h0000;
                    busy <= 1'b1;
                end
            end else if (rise) begin
                rx <= in_byte[6:0];
                addr_sh <= addr_next;
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                if (last_bit && state == CMD) begin
                    last_cmd <= in_byte;
                    cmd_err <= !cmd_ok;
                end
                if (last_bit && state == ADDR) begin
                    ptr <= addr_next;
                    load <= last_cmd == 8'h03;
                end
                if (last_bit && state == RD_DATA) begin
                    ptr <= ptr + ADDR_W'(1);
                    load <= 1'b1;
                    byte_cnt <= byte_inc;
                end
                if (last_bit && state == WR_DATA) begin
                    wr_pend <= 1'b1;
                    wr_byte <= in_byte;
                end
            end else if (fall && state == RD_DATA) begin
                miso <= tx[7];
                miso_oe <= 1'b1;
                tx <= {tx[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed SPI transactions against a byte-array memory model,
// with a per-cycle compare process for miso/miso_oe/busy.
module tb_spi_mem_responder;
    logic clk = 1'b0, rst = 1'b1, cs = 1'b1, sck = 1'b0, mosi = 1'b0, hold_n = 1'b1;
    logic miso, miso_oe, busy, cmd_err;
    logic [7:0] last_cmd;
    logic [15:0] byte_cnt;
    int total = 0, bad = 0, req = 0, seen = 0, err_pulses = 0;
    logic exp_miso = 1'b0, exp_oe = 1'b0, exp_busy = 1'b0;
    logic [7:0] ref_mem [256];

    spi_mem_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi), .hold_n(hold_n),
        .miso(miso), .miso_oe(miso_oe), .busy(busy), .last_cmd(last_cmd),
        .cmd_err(cmd_err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // the single compare process: idle-miso rule every cycle, model bits at each master sample point
    always @(negedge clk) begin
        if (cmd_err) err_pulses++;
        if (!rst) chk("miso_quiet", {31'd0, miso & ~miso_oe}, 32'd0);
        if (req != seen) begin
            seen = req;
            chk("miso_bit", {31'd0, miso}, {31'd0, exp_miso});
            chk("miso_oe_bit", {31'd0, miso_oe}, {31'd0, exp_oe});
            chk("busy_bit", {31'd0, busy}, {31'd0, exp_busy});
        end
    end

    task automatic sbit(input logic b, input logic em, input logic eo, input logic eb, output logic r);
        mosi = b;
        wait_clk(7);
        exp_miso = em;
        exp_oe = eo;
        exp_busy = eb;
        req++;
        wait_clk(1);
        r = miso;
        sck = 1'b1;
        wait_clk(8);
        sck = 1'b0;
    endtask

    task automatic do_hold();
        wait_clk(8);
        hold_n = 1'b0;
        wait_clk(2);
        repeat (3) begin
            sck = 1'b1;
            wait_clk(8);
            sck = 1'b0;
            wait_clk(8);
        end
        hold_n = 1'b1;
        wait_clk(2);
    endtask

    task automatic txn(input logic [7:0] op, input logic [23:0] a, input int ndata,
                       input logic [31:0] wd, input int hold_at, output logic [31:0] rdat);
        logic r, rdop, known;
        int p, e0;
        rdop = op == 8'h03;
        known = op == 8'h02 || op == 8'h03;
        e0 = err_pulses;
        rdat = 32'd0;
        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 32; i++) sbit(i < 8 ? op[7-i] : a[31-i], 1'b0, 1'b0, 1'b1, r);
        for (int d = 0; d < ndata; d++) begin
            if (d == hold_at) do_hold();
            p = (int'(a[7:0]) + d / 8) % 256;
            sbit(wd[31-d], rdop & ref_mem[p][7 - d % 8], rdop, 1'b1, r);
            rdat[31-d] = r;
            if (op == 8'h02 && d % 8 == 7) ref_mem[p] = wd[31-d +: 8];
        end
        wait_clk(8);
        cs = 1'b1;
        wait_clk(12);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("miso_oe_end", {31'd0, miso_oe}, 32'd0);
        chk("last_cmd", {24'd0, last_cmd}, {24'd0, op});
        chk("byte_cnt", {16'd0, byte_cnt}, known ? ndata / 8 : 0);
        chk("cmd_err_pulses", err_pulses - e0, known ? 0 : 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0] op_rd;
        logic r;
        op_rd = 8'h03;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_last_cmd", {24'd0, last_cmd}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        chk("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);

        txn(8'h02, 24'h000010, 32, 32'hDEADBEEF, -1, rd);
        txn(8'h03, 24'h000010, 32, 32'd0, -1, rd);
        chk("read_deadbeef", rd, 32'hDEADBEEF);
        txn(8'h03, 24'hAB0010, 32, 32'd0, -1, rd);
        chk("read_high_addr_ignored", rd, 32'hDEADBEEF);

        txn(8'h02, 24'h0000FE, 32, 32'h11223344, -1, rd);
        txn(8'h03, 24'h000000, 16, 32'd0, -1, rd);
        chk("wrap_read_0", {16'd0, rd[31:16]}, 32'h3344);
        txn(8'h03, 24'h0000FE, 32, 32'd0, -1, rd);
        chk("wrap_read_fe", rd, 32'h11223344);

        txn(8'h02, 24'h000020, 16, 32'h55660000, -1, rd);
        txn(8'h02, 24'h000020, 12, 32'hABC00000, -1, rd);
        txn(8'h03, 24'h000020, 16, 32'd0, -1, rd);
        chk("partial_byte", {16'd0, rd[31:16]}, 32'hAB66);

        txn(8'h9F, 24'h000010, 0, 32'd0, -1, rd);
        chk("bad_op_last_cmd", {24'd0, last_cmd}, 32'h9F);

        txn(8'h03, 24'h000010, 32, 32'd0, 10, rd);
        chk("hold_read", rd, 32'hDEADBEEF);

        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 18; i++) sbit(i < 8 ? op_rd[7-i] : 1'b0, 1'b0, 1'b0, 1'b1, r);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("abort_last_cmd", {24'd0, last_cmd}, 32'd0);
        chk("abort_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        for (int i = 0; i < 14; i++) sbit(1'b0, 1'b0, 1'b0, 1'b0, r);
        wait_clk(8);
        cs = 1'b1;
        wait_clk(12);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        txn(8'h03, 24'h000010, 32, 32'd0, -1, rd);
        chk("read_after_reset", rd, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
